// File: rtl/regfile_mp.sv
// Multi-port register file: sized/extended combinational reads, lane-merging clocked writes,
// optional register-zero hardwiring and a per-register pending-write scoreboard.
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  input  logic [1:0]            rd_size,
  input  logic                  rd_signed,
  output logic [NRD*DATA_W-1:0] rd_data,
  output logic [NRD-1:0]        rd_busy,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [1:0]            wr_size,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  sb_set,
  input  logic [ADDR_W-1:0]     sb_addr,
  output logic                  busy_any
);

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;

  logic wr_ok;
  logic sb_ok;

  // An address is live when it is in range and not the hardwired zero register.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    logic in_range;
    logic is_zero;
    in_range = ({{(32-ADDR_W){1'b0}}, a} < 32'(DEPTH));
    is_zero  = (ZERO_REG != 0) && (a == '0);
    return in_range && !is_zero;
  endfunction

  function automatic logic [DATA_W-1:0] lane_merge(
    input logic [DATA_W-1:0] old_w,
    input logic [DATA_W-1:0] new_w,
    input logic [1:0]        size
  );
    logic [DATA_W-1:0] res;
    case (size)
      SIZE_BYTE: res = {old_w[DATA_W-1:8],  new_w[7:0]};
      SIZE_HALF: res = {old_w[DATA_W-1:16], new_w[15:0]};
      default:   res = new_w;
    endcase
    return res;
  endfunction

  function automatic logic [DATA_W-1:0] extend(
    input logic [DATA_W-1:0] w,
    input logic [1:0]        size,
    input logic              sgn
  );
    logic [DATA_W-1:0] res;
    case (size)
      SIZE_BYTE: res = {{(DATA_W-8){sgn & w[7]}},   w[7:0]};
      SIZE_HALF: res = {{(DATA_W-16){sgn & w[15]}}, w[15:0]};
      default:   res = w;
    endcase
    return res;
  endfunction

  assign wr_ok = wr_en  && addr_ok(wr_addr);
  assign sb_ok = sb_set && addr_ok(sb_addr);

  // Write clears the pending bit first so a same-edge sb_set to that register wins.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    for (int j = 0; j < DEPTH; j++) begin
      if (wr_ok && (wr_addr == ADDR_W'(j))) begin
        regs_d[j] = lane_merge(regs_q[j], wr_data, wr_size);
        busy_d[j] = 1'b0;
      end
      if (sb_ok && (sb_addr == ADDR_W'(j))) begin
        busy_d[j] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < DEPTH; j++) begin
        regs_q[j] <= '0;
      end
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  assign busy_any = |busy_q;

  genvar gi;
  generate
    for (gi = 0; gi < NRD; gi++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      logic [DATA_W-1:0] word;
      logic              busy_bit;

      assign ra = rd_addr[gi*ADDR_W +: ADDR_W];

      always_comb begin
        word     = '0;
        busy_bit = 1'b0;
        if (addr_ok(ra)) begin
          for (int j = 0; j < DEPTH; j++) begin
            if (ra == ADDR_W'(j)) begin
              word     = regs_q[j];
              busy_bit = busy_q[j];
            end
          end
`ifdef REGFILE_BYPASS_EN
          // Forward the merged post-write word; busy bits are never forwarded.
          if (wr_ok && (ra == wr_addr)) begin
            word = lane_merge(word, wr_data, wr_size);
          end
`endif
        end
      end

      assign rd_data[gi*DATA_W +: DATA_W] = extend(word, rd_size, rd_signed);
      assign rd_busy[gi]                  = busy_bit;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: stimulus pushes expected read results into a queue and a
// negedge monitor pops and compares them against the DUT outputs.
module tb_regfile_mp;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 24;
  localparam int ADDR_W = 5;
  localparam int NRD    = 2;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                  clk;
  logic                  rst_n;
  logic [NRD*ADDR_W-1:0] rd_addr;
  logic [1:0]            rd_size;
  logic                  rd_signed;
  logic [NRD*DATA_W-1:0] rd_data;
  logic [NRD-1:0]        rd_busy;
  logic                  wr_en;
  logic [ADDR_W-1:0]     wr_addr;
  logic [1:0]            wr_size;
  logic [DATA_W-1:0]     wr_data;
  logic                  sb_set;
  logic [ADDR_W-1:0]     sb_addr;
  logic                  busy_any;

  regfile_mp #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .NRD(NRD), .ZERO_REG(1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_addr(rd_addr), .rd_size(rd_size), .rd_signed(rd_signed),
    .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_size(wr_size), .wr_data(wr_data),
    .sb_set(sb_set), .sb_addr(sb_addr), .busy_any(busy_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] e0;
    logic [31:0] e1;
    logic [1:0]  eb;
    logic        ea;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;

  localparam logic [1:0] SB = 2'b00;
  localparam logic [1:0] SH = 2'b01;
  localparam logic [1:0] SW = 2'b10;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      checks++;
      if (rd_data[31:0] !== e.e0 || rd_data[63:32] !== e.e1 ||
          rd_busy !== e.eb || busy_any !== e.ea) begin
        errors++;
        $display("FAIL %s: got d0=%h d1=%h busy=%b any=%b, want d0=%h d1=%h busy=%b any=%b",
                 n, rd_data[31:0], rd_data[63:32], rd_busy, busy_any, e.e0, e.e1, e.eb, e.ea);
      end else begin
        $display("ok   %s: d0=%h d1=%h busy=%b any=%b", n, rd_data[31:0], rd_data[63:32],
                 rd_busy, busy_any);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    wr_en  = 1'b0;
    sb_set = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [1:0] sz);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    wr_size = sz;
  endtask

  task automatic sb(input logic [4:0] a);
    sb_set  = 1'b1;
    sb_addr = a;
  endtask

  // Drive read inputs for this cycle, queue the expectation, then advance one cycle.
  task automatic chk(input string nm, input logic [4:0] a0, input logic [4:0] a1,
                     input logic [1:0] sz, input logic sg,
                     input logic [31:0] e0, input logic [31:0] e1,
                     input logic [1:0] eb, input logic ea);
    exp_t e;
    rd_addr   = {a1, a0};
    rd_size   = sz;
    rd_signed = sg;
    e.e0 = e0; e.e1 = e1; e.eb = eb; e.ea = ea;
    exp_q.push_back(e);
    name_q.push_back(nm);
    tick();
  endtask

  initial begin
    rst_n = 1'b0; rd_addr = '0; rd_size = SW; rd_signed = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_size = SW; wr_data = '0;
    sb_set = 1'b0; sb_addr = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    chk("reset_state", 5'd0, 5'd1, SW, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);

    // Asynchronous reset between edges, with a write in flight that must be dropped
    wr(5'd5, 32'hDEADBEEF, SW); tick();
    sb(5'd2);
    chk("r5_written", 5'd5, 5'd5, SW, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 1'b0);
    wr(5'd6, 32'h12345678, SW);
    rst_n = 1'b0;
    chk("async_reset", 5'd5, 5'd2, SW, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    rst_n = 1'b1;
    chk("reset_write_dropped", 5'd6, 5'd5, SW, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);

    // Sub-word writes keep untouched lanes
    wr(5'd3, 32'h11223344, SW); tick();
    wr(5'd3, 32'hFFFFFFAB, SB); tick();
    chk("byte_write", 5'd3, 5'd3, SW, 1'b0, 32'h112233AB, 32'h112233AB, 2'b00, 1'b0);
    wr(5'd3, 32'hFFFFCDEF, SH); tick();
    chk("half_write", 5'd3, 5'd0, SW, 1'b0, 32'h1122CDEF, 32'h0, 2'b00, 1'b0);

    // Read size and extension
    wr(5'd7, 32'h000000F0, SW); tick();
    chk("byte_zext", 5'd7, 5'd3, SB, 1'b0, 32'h000000F0, 32'h000000EF, 2'b00, 1'b0);
    chk("byte_sext", 5'd7, 5'd3, SB, 1'b1, 32'hFFFFFFF0, 32'hFFFFFFEF, 2'b00, 1'b0);
    wr(5'd7, 32'h00008001, SW); tick();
    chk("half_sext", 5'd7, 5'd3, SH, 1'b1, 32'hFFFF8001, 32'hFFFFCDEF, 2'b00, 1'b0);
    chk("half_zext", 5'd7, 5'd3, SH, 1'b0, 32'h00008001, 32'h0000CDEF, 2'b00, 1'b0);
    chk("size11_word", 5'd7, 5'd3, 2'b11, 1'b1, 32'h00008001, 32'h1122CDEF, 2'b00, 1'b0);

    // Hardwired zero register and out-of-range addresses
    wr(5'd0, 32'h00000055, SW); sb(5'd0); tick();
    chk("r0_ignored", 5'd0, 5'd0, SW, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    wr(5'd30, 32'h0000AAAA, SW); sb(5'd30); tick();
    chk("r30_ignored", 5'd30, 5'd23, SW, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    wr(5'd23, 32'h23232323, SW); tick();
    chk("r23_top", 5'd23, 5'd30, SW, 1'b0, 32'h23232323, 32'h0, 2'b00, 1'b0);

    // Scoreboard set/clear ordering
    sb(5'd9);
    chk("sb_same_cycle", 5'd9, 5'd9, SW, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    chk("sb_set_r9", 5'd9, 5'd1, SW, 1'b0, 32'h0, 32'h0, 2'b01, 1'b1);
    wr(5'd9, 32'h00000099, SW); sb(5'd9); tick();
    chk("sb_and_write_r9", 5'd9, 5'd9, SW, 1'b0, 32'h99, 32'h99, 2'b11, 1'b1);
    wr(5'd9, 32'h00000077, SW); tick();
    chk("write_clears_r9", 5'd9, 5'd9, SW, 1'b0, 32'h77, 32'h77, 2'b00, 1'b0);
    wr(5'd11, 32'h00001111, SW); sb(5'd10); tick();
    chk("sb_r10_wr_r11", 5'd10, 5'd11, SW, 1'b0, 32'h0, 32'h1111, 2'b01, 1'b1);
    wr(5'd10, 32'h00000010, SH); tick();
    chk("half_write_clears", 5'd11, 5'd10, SW, 1'b0, 32'h1111, 32'h10, 2'b00, 1'b0);

    // Same-cycle read-after-write, with and without forwarding
    wr(5'd4, 32'h12345678, SW);
    chk("raw_same_cycle", 5'd4, 5'd4, SW, 1'b0,
        BYP ? 32'h12345678 : 32'h0, BYP ? 32'h12345678 : 32'h0, 2'b00, 1'b0);
    chk("raw_next_cycle", 5'd4, 5'd4, SW, 1'b0, 32'h12345678, 32'h12345678, 2'b00, 1'b0);
    wr(5'd4, 32'h000000AA, SB);
    chk("raw_byte_merge", 5'd4, 5'd7, SH, 1'b0,
        BYP ? 32'h000056AA : 32'h00005678, 32'h00008001, 2'b00, 1'b0);
    chk("byte_merge_after", 5'd4, 5'd4, SW, 1'b0, 32'h123456AA, 32'h123456AA, 2'b00, 1'b0);
    wr(5'd0, 32'h00000055, SW); sb(5'd4);
    chk("raw_r0_no_fwd", 5'd0, 5'd4, SW, 1'b0, 32'h0, 32'h123456AA, 2'b00, 1'b0);
    chk("sb_no_fwd_after", 5'd0, 5'd4, SW, 1'b0, 32'h0, 32'h123456AA, 2'b10, 1'b1);

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
